// File: rtl/rvfi_consistency_checker.sv
// ---------------------------------------------------------------------------
// rvfi_consistency_checker
//
// Purpose:
//   Watches the RVFI retirement stream of a RISC-V core. Each retired packet
//   (rvfi_valid high) is checked against the previous packet and against a
//   shadow copy of the architectural register file. The checks are:
//     - order continuity
//     - PC continuity
//     - stale rs1/rs2 reads
//     - writes of a nonzero value to x0
//     - optionally, memory mask sanity
//   Error bits are sticky. The rvfi_order of the first offending packet is
//   captured.
//
// Parameters:
//   HALT_ON_ERROR : 1 = freeze in HALT on the first error,
//                   0 = keep checking and accumulate errors.
//   CHECK_PC      : 1 = enable the PC continuity check (error bit 1).
//
// Optional feature macro:
//   RVFI_CHK_MEM_EN : when defined, error bit 5 flags illegal or
//                     inconsistent memory byte masks and data lanes.
//                     When undefined, bit 5 is tied to 0.
//
// Ports:
//   clock, reset_n     : rising-edge clock, asynchronous active-low reset
//   chk_clear          : synchronous clear of all checker state; it wins over
//                        a packet presented in the same cycle
//   rvfi_*             : retirement packet fields from the RVFI monitor
//   chk_state          : 0 IDLE, 1 RUN, 2 HALT
//   chk_error          : OR of all sticky error bits
//   chk_err_code       : sticky error bits
//                        [0] order  [1] pc  [2] rs1  [3] rs2  [4] x0  [5] mem
//   chk_err_order      : rvfi_order of the first erroring packet
//   chk_retired        : number of accepted packets (wraps at 2^32)
// ---------------------------------------------------------------------------
module rvfi_consistency_checker #(
  parameter int unsigned HALT_ON_ERROR = 1,
  parameter int unsigned CHECK_PC      = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        chk_clear,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  output logic [1:0]  chk_state,
  output logic        chk_error,
  output logic [5:0]  chk_err_code,
  output logic [63:0] chk_err_order,
  output logic [31:0] chk_retired
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } chkState_t;

  chkState_t   r_state;
  chkState_t   w_nextState;

  logic [5:0]  r_errCode;
  logic [63:0] r_errOrder;
  logic [31:0] r_retired;

  // Shadow register file. Entry 0 is never written because x0 updates are
  // skipped, so its valid bit stays 0.
  logic [31:0] r_shadow [32];
  logic [31:0] r_shadowValid;

  logic [63:0] r_prevOrder;
  logic [31:0] r_prevPcWdata;
  logic        r_prevTrap;

  logic        w_accept;
  logic        w_running;
  logic        w_orderErr;
  logic        w_pcErr;
  logic        w_rs1Err;
  logic        w_rs2Err;
  logic        w_x0Err;
  logic        w_memErr;
  logic [5:0]  w_newErr;
  logic        w_anyErr;
  logic        w_haltOnErr;
  logic        w_checkPc;

  assign w_haltOnErr = (HALT_ON_ERROR != 0);
  assign w_checkPc   = (CHECK_PC != 0);

  // A packet is accepted only in IDLE or RUN, and only when no clear is
  // pending. HALT ignores all traffic.
  assign w_accept  = rvfi_valid && !chk_clear &&
                     ((r_state == ST_IDLE) || (r_state == ST_RUN));
  // In IDLE the packet is only a baseline, so there is no previous packet
  // to compare order or PC against.
  assign w_running = (r_state == ST_RUN);

  assign w_orderErr = w_running && (rvfi_order != (r_prevOrder + 64'd1));
  // A trap redirects the PC, so continuity is not expected after one.
  assign w_pcErr    = w_checkPc && w_running && !r_prevTrap &&
                      (rvfi_pc_rdata != r_prevPcWdata);

  // Register read checks use the shadow contents from before this packet's
  // own writeback, so rd == rs1 compares against the old value.
  assign w_rs1Err = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != 32'd0)) ||
                    (r_shadowValid[rvfi_rs1_addr] &&
                     (rvfi_rs1_rdata != r_shadow[rvfi_rs1_addr]));
  assign w_rs2Err = ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != 32'd0)) ||
                    (r_shadowValid[rvfi_rs2_addr] &&
                     (rvfi_rs2_rdata != r_shadow[rvfi_rs2_addr]));
  assign w_x0Err  = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);

`ifdef RVFI_CHK_MEM_EN
  // Only naturally aligned byte, halfword and word accesses are legal.
  function automatic logic isLegalMask(input logic [3:0] mask);
    logic legal;
    legal = 1'b0;
    case (mask)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [31:0] laneBits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

  logic w_unusedBits;
  assign w_unusedBits = ^rvfi_insn;

  // Data bits in lanes that the mask excludes must be zero.
  always_comb begin
    w_memErr = 1'b0;
    if ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0)) begin
      w_memErr = 1'b1;
    end
    if (!isLegalMask(rvfi_mem_rmask) || !isLegalMask(rvfi_mem_wmask)) begin
      w_memErr = 1'b1;
    end
    if ((rvfi_mem_rdata & ~laneBits(rvfi_mem_rmask)) != 32'd0) begin
      w_memErr = 1'b1;
    end
    if ((rvfi_mem_wdata & ~laneBits(rvfi_mem_wmask)) != 32'd0) begin
      w_memErr = 1'b1;
    end
  end
`else
  logic w_unusedBits;
  assign w_unusedBits = ^{rvfi_insn, rvfi_mem_rmask, rvfi_mem_wmask,
                          rvfi_mem_rdata, rvfi_mem_wdata};
  assign w_memErr     = 1'b0;
`endif

  assign w_newErr = w_accept ? {w_memErr, w_x0Err, w_rs2Err, w_rs1Err,
                                w_pcErr, w_orderErr} : 6'd0;
  assign w_anyErr = |w_newErr;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. The first packet moves IDLE to RUN. Any error moves to
  // HALT when halting is enabled. HALT is left only by clear or by reset.
  always_comb begin
    w_nextState = r_state;
    if (chk_clear) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_accept) begin
            w_nextState = (w_anyErr && w_haltOnErr) ? ST_HALT : ST_RUN;
          end
        end
        ST_HALT: w_nextState = ST_HALT;
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  // Sticky error bits, first-error order, retired counter and history of
  // the previous packet. The erroring packet itself still counts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_errCode     <= 6'd0;
      r_errOrder    <= 64'd0;
      r_retired     <= 32'd0;
      r_prevOrder   <= 64'd0;
      r_prevPcWdata <= 32'd0;
      r_prevTrap    <= 1'b0;
    end else if (chk_clear) begin
      r_errCode     <= 6'd0;
      r_errOrder    <= 64'd0;
      r_retired     <= 32'd0;
      r_prevOrder   <= 64'd0;
      r_prevPcWdata <= 32'd0;
      r_prevTrap    <= 1'b0;
    end else if (w_accept) begin
      r_errCode     <= r_errCode | w_newErr;
      r_retired     <= r_retired + 32'd1;
      r_prevOrder   <= rvfi_order;
      r_prevPcWdata <= rvfi_pc_wdata;
      r_prevTrap    <= rvfi_trap;
      if (w_anyErr && (r_errCode == 6'd0)) begin
        r_errOrder <= rvfi_order;
      end
    end
  end

  // Shadow valid bits need a reset. The data array does not, because an
  // entry is never read while its valid bit is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadowValid <= 32'd0;
    end else if (chk_clear) begin
      r_shadowValid <= 32'd0;
    end else if (w_accept && (rvfi_rd_addr != 5'd0)) begin
      r_shadowValid[rvfi_rd_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept && (rvfi_rd_addr != 5'd0)) begin
      r_shadow[rvfi_rd_addr] <= rvfi_rd_wdata;
    end
  end

  assign chk_state     = r_state;
  assign chk_err_code  = r_errCode;
  assign chk_error     = |r_errCode;
  assign chk_err_order = r_errOrder;
  assign chk_retired   = r_retired;

endmodule

// File: tb/tb_rvfi_consistency_checker.sv
// ---------------------------------------------------------------------------
// tb_rvfi_consistency_checker
//
// Purpose:
//   Drives directed RVFI packets into two checker instances that share the
//   same inputs:
//     dutA : HALT_ON_ERROR = 1
//     dutB : HALT_ON_ERROR = 0
//   Hand-computed expectations are queued as each packet is issued. A
//   monitor pops and compares them one clock after the packet.
//
// Optional feature macro:
//   RVFI_CHK_MEM_EN : also run the memory mask scenarios.
// ---------------------------------------------------------------------------
module tb_rvfi_consistency_checker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        chk_clear;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic [4:0]  rvfi_rs1_addr;
  logic [4:0]  rvfi_rs2_addr;
  logic [31:0] rvfi_rs1_rdata;
  logic [31:0] rvfi_rs2_rdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata;
  logic [31:0] rvfi_mem_wdata;

  logic [1:0]  stateA;
  logic [1:0]  stateB;
  logic        errorA;
  logic        errorB;
  logic [5:0]  codeA;
  logic [5:0]  codeB;
  logic [63:0] orderA;
  logic [63:0] orderB;
  logic [31:0] retiredA;
  logic [31:0] retiredB;

  typedef struct {
    int          cycle;
    bit          sel;
    logic [1:0]  state;
    logic [5:0]  code;
    logic [63:0] order;
    logic [31:0] retired;
    string       name;
  } expect_t;

  expect_t expQ[$];
  int      cycleCount = 0;
  int      checkCount = 0;
  int      errorCount = 0;

  always #5 clock = ~clock;

  rvfi_consistency_checker #(
    .HALT_ON_ERROR(1),
    .CHECK_PC(1)
  ) dutA (
    .clock(clock),
    .reset_n(reset_n),
    .chk_clear(chk_clear),
    .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap),
    .rvfi_rs1_addr(rvfi_rs1_addr),
    .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata),
    .chk_state(stateA),
    .chk_error(errorA),
    .chk_err_code(codeA),
    .chk_err_order(orderA),
    .chk_retired(retiredA)
  );

  rvfi_consistency_checker #(
    .HALT_ON_ERROR(0),
    .CHECK_PC(1)
  ) dutB (
    .clock(clock),
    .reset_n(reset_n),
    .chk_clear(chk_clear),
    .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap),
    .rvfi_rs1_addr(rvfi_rs1_addr),
    .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata),
    .chk_state(stateB),
    .chk_error(errorB),
    .chk_err_code(codeB),
    .chk_err_order(orderB),
    .chk_retired(retiredB)
  );

  // Compare one field and count the result.
  task automatic compareField(input string name, input string field,
                              input logic [63:0] actual,
                              input logic [63:0] required);
    checkCount++;
    if (actual !== required) begin
      errorCount++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h", name, field,
               actual, required);
    end
  endtask

  // Check one queued expectation against the selected instance.
  task automatic checkOutput(input expect_t e);
    logic [1:0]  aState;
    logic        aErr;
    logic [5:0]  aCode;
    logic [63:0] aOrder;
    logic [31:0] aRet;
    string       tag;
    if (e.sel) begin
      aState = stateB;
      aErr   = errorB;
      aCode  = codeB;
      aOrder = orderB;
      aRet   = retiredB;
      tag    = {e.name, "/B"};
    end else begin
      aState = stateA;
      aErr   = errorA;
      aCode  = codeA;
      aOrder = orderA;
      aRet   = retiredA;
      tag    = {e.name, "/A"};
    end
    compareField(tag, "state",   {62'd0, aState}, {62'd0, e.state});
    compareField(tag, "code",    {58'd0, aCode},  {58'd0, e.code});
    compareField(tag, "error",   {63'd0, aErr},   {63'd0, (|e.code)});
    compareField(tag, "errOrd",  aOrder,          e.order);
    compareField(tag, "retired", {32'd0, aRet},   {32'd0, e.retired});
  endtask

  // Monitor: after each rising edge, check everything due this cycle.
  initial begin
    expect_t e;
    forever begin
      @(posedge clock);
      cycleCount++;
      #1;
      while ((expQ.size() > 0) && (expQ[0].cycle <= cycleCount)) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic expectOne(input bit sel, input logic [1:0] state,
                           input logic [5:0] code, input logic [63:0] order,
                           input logic [31:0] retired, input string name);
    expect_t e;
    e.cycle   = cycleCount + 1;
    e.sel     = sel;
    e.state   = state;
    e.code    = code;
    e.order   = order;
    e.retired = retired;
    e.name    = name;
    expQ.push_back(e);
  endtask

  task automatic expectBoth(input logic [1:0] state, input logic [5:0] code,
                            input logic [63:0] order,
                            input logic [31:0] retired, input string name);
    expectOne(1'b0, state, code, order, retired, name);
    expectOne(1'b1, state, code, order, retired, name);
  endtask

  // Drive one valid packet at the falling edge. Memory fields default to 0.
  task automatic applyStimulus(input logic [63:0] order,
                               input logic [31:0] pcR, input logic [31:0] pcW,
                               input logic trap,
                               input logic [4:0] rs1a, input logic [31:0] rs1d,
                               input logic [4:0] rs2a, input logic [31:0] rs2d,
                               input logic [4:0] rda, input logic [31:0] rdd);
    @(negedge clock);
    chk_clear      = 1'b0;
    rvfi_valid     = 1'b1;
    rvfi_order     = order;
    rvfi_insn      = 32'h0000_0013;
    rvfi_pc_rdata  = pcR;
    rvfi_pc_wdata  = pcW;
    rvfi_trap      = trap;
    rvfi_rs1_addr  = rs1a;
    rvfi_rs1_rdata = rs1d;
    rvfi_rs2_addr  = rs2a;
    rvfi_rs2_rdata = rs2d;
    rvfi_rd_addr   = rda;
    rvfi_rd_wdata  = rdd;
    rvfi_mem_rmask = 4'd0;
    rvfi_mem_wmask = 4'd0;
    rvfi_mem_rdata = 32'd0;
    rvfi_mem_wdata = 32'd0;
  endtask

  task automatic applyIdle();
    @(negedge clock);
    chk_clear  = 1'b0;
    rvfi_valid = 1'b0;
  endtask

  task automatic applyClear(input logic withPacket);
    @(negedge clock);
    chk_clear  = 1'b1;
    rvfi_valid = withPacket;
  endtask

  initial begin
    reset_n        = 1'b0;
    chk_clear      = 1'b0;
    rvfi_valid     = 1'b0;
    rvfi_order     = 64'd0;
    rvfi_insn      = 32'd0;
    rvfi_trap      = 1'b0;
    rvfi_rs1_addr  = 5'd0;
    rvfi_rs2_addr  = 5'd0;
    rvfi_rs1_rdata = 32'd0;
    rvfi_rs2_rdata = 32'd0;
    rvfi_rd_addr   = 5'd0;
    rvfi_rd_wdata  = 32'd0;
    rvfi_pc_rdata  = 32'd0;
    rvfi_pc_wdata  = 32'd0;
    rvfi_mem_rmask = 4'd0;
    rvfi_mem_wmask = 4'd0;
    rvfi_mem_rdata = 32'd0;
    rvfi_mem_wdata = 32'd0;

    // Reset state.
    @(negedge clock);
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Clean stream. rd == rs1 in p3 must be checked against the old x5.
    applyStimulus(64'd1, 32'h0, 32'h4, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd5, 32'h11);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd1, "clean_p1");
    applyStimulus(64'd2, 32'h4, 32'h8, 1'b0, 5'd5, 32'h11, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd2, "clean_p2");
    applyStimulus(64'd3, 32'h8, 32'hC, 1'b0, 5'd5, 32'h11, 5'd0, 32'd0,
                  5'd5, 32'h22);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd3, "clean_p3");
    applyStimulus(64'd4, 32'hC, 32'h10, 1'b0, 5'd5, 32'h22, 5'd5, 32'h22,
                  5'd0, 32'd0);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd4, "clean_p4");
    applyIdle();
    expectBoth(2'd1, 6'h00, 64'd0, 32'd4, "clean_idle");

    // A clear with a packet present drops the packet.
    applyClear(1'b1);
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "clear_drop");

    // Order gap 1 -> 3.
    applyStimulus(64'd1, 32'h0, 32'h4, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd1, "gap_p1");
    applyStimulus(64'd3, 32'h4, 32'h8, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectOne(1'b0, 2'd2, 6'h01, 64'd3, 32'd2, "gap_p2");
    expectOne(1'b1, 2'd1, 6'h01, 64'd3, 32'd2, "gap_p2");
    applyStimulus(64'd4, 32'h8, 32'hC, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectOne(1'b0, 2'd2, 6'h01, 64'd3, 32'd2, "gap_p3");
    expectOne(1'b1, 2'd1, 6'h01, 64'd3, 32'd3, "gap_p3");

    // Asynchronous reset while dutA sits in HALT.
    @(negedge clock);
    rvfi_valid = 1'b0;
    reset_n    = 1'b0;
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "reset_halt");
    @(negedge clock);
    reset_n = 1'b1;

    // Stale rs2 read of x7. The read of x9 is fine because x9 was never
    // written.
    applyStimulus(64'd10, 32'h100, 32'h104, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd7, 32'hAA);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd1, "stale_p1");
    applyStimulus(64'd11, 32'h104, 32'h108, 1'b0, 5'd9, 32'h1234, 5'd7,
                  32'hAB, 5'd0, 32'd0);
    expectOne(1'b0, 2'd2, 6'h08, 64'd11, 32'd2, "stale_p2");
    expectOne(1'b1, 2'd1, 6'h08, 64'd11, 32'd2, "stale_p2");

    // A write to x0 in the baseline packet, then an order gap.
    applyClear(1'b0);
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "clear_x0");
    applyStimulus(64'd20, 32'h0, 32'h4, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'h1);
    expectOne(1'b0, 2'd2, 6'h10, 64'd20, 32'd1, "x0_p1");
    expectOne(1'b1, 2'd1, 6'h10, 64'd20, 32'd1, "x0_p1");
    applyStimulus(64'd22, 32'h4, 32'h8, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectOne(1'b0, 2'd2, 6'h10, 64'd20, 32'd1, "x0_p2");
    expectOne(1'b1, 2'd1, 6'h11, 64'd20, 32'd2, "x0_p2");

    // After a trap the PC may jump. Without a trap it must not.
    applyClear(1'b0);
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "clear_pc");
    applyStimulus(64'd1, 32'h0, 32'h10, 1'b1, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd1, "pc_p1");
    applyStimulus(64'd2, 32'h80, 32'h84, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd2, "pc_trap_ok");
    applyStimulus(64'd3, 32'h90, 32'h94, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectOne(1'b0, 2'd2, 6'h02, 64'd3, 32'd3, "pc_jump");
    expectOne(1'b1, 2'd1, 6'h02, 64'd3, 32'd3, "pc_jump");

    // 64-bit order wrap is legal. A nonzero read of x0 is an rs1 error.
    applyClear(1'b0);
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "clear_wrap");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h4, 1'b0, 5'd0, 32'd0,
                  5'd0, 32'd0, 5'd0, 32'd0);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd1, "wrap_p1");
    applyStimulus(64'd0, 32'h4, 32'h8, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectBoth(2'd1, 6'h00, 64'd0, 32'd2, "wrap_p2");
    applyStimulus(64'd1, 32'h8, 32'hC, 1'b0, 5'd0, 32'd5, 5'd0, 32'd0,
                  5'd0, 32'd0);
    expectOne(1'b0, 2'd2, 6'h04, 64'd1, 32'd3, "rs1_x0");
    expectOne(1'b1, 2'd1, 6'h04, 64'd1, 32'd3, "rs1_x0");

`ifdef RVFI_CHK_MEM_EN
    // Read data outside the byte lanes enabled by rmask.
    applyClear(1'b0);
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "clear_mem1");
    applyStimulus(64'd1, 32'h0, 32'h4, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    rvfi_mem_rmask = 4'b0001;
    rvfi_mem_rdata = 32'h0000_0100;
    expectOne(1'b0, 2'd2, 6'h20, 64'd1, 32'd1, "mem_lane");
    expectOne(1'b1, 2'd1, 6'h20, 64'd1, 32'd1, "mem_lane");

    // Read and write masks set in the same packet.
    applyClear(1'b0);
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "clear_mem2");
    applyStimulus(64'd5, 32'h0, 32'h4, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    rvfi_mem_rmask = 4'b0011;
    rvfi_mem_wmask = 4'b0011;
    expectOne(1'b0, 2'd2, 6'h20, 64'd5, 32'd1, "mem_rw");
    expectOne(1'b1, 2'd1, 6'h20, 64'd5, 32'd1, "mem_rw");

    // A full-word read is legal.
    applyClear(1'b0);
    expectBoth(2'd0, 6'h00, 64'd0, 32'd0, "clear_mem3");
    applyStimulus(64'd7, 32'h0, 32'h4, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0,
                  5'd0, 32'd0);
    rvfi_mem_rmask = 4'b1111;
    rvfi_mem_rdata = 32'hDEAD_BEEF;
    expectBoth(2'd1, 6'h00, 64'd0, 32'd1, "mem_ok");
`endif

    applyIdle();
    repeat (3) @(negedge clock);
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
